// File: rtl/memtest_pkg.sv
// Shared types and helpers for the SDRAM memory-test master.
//   state_e        : top-level FSM states
//   LFSR_MASK      : Galois feedback mask for the optional LFSR pattern
//   next_pattern() : one Galois LFSR step
package memtest_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  function automatic logic [15:0] next_pattern(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction
endpackage

// File: rtl/memtest_pattern_gen.sv
// Test-pattern generator. One instance produces write data and a second one
// reproduces the same sequence for checking read data.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the sequence from its first value
//   advance    : step to the next value
//   pattern    : current pattern word
// MEMTEST_LFSR_EN selects a 16-bit Galois LFSR seeded with SEED; otherwise the
// pattern is the word index XOR SEED and no LFSR logic exists.
module memtest_pattern_gen
  import memtest_pkg::*;
#(
  parameter int          DATA_W = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [DATA_W-1:0] pattern
);
`ifdef MEMTEST_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (clear)        lfsr_d = SEED;
    else if (advance) lfsr_d = next_pattern(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;

  assign pattern = DATA_W'(lfsr_q);
`else
  logic [DATA_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clear)        idx_d = '0;
    else if (advance) idx_d = idx_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;

  assign pattern = idx_q ^ DATA_W'(SEED);
`endif
endmodule

// File: rtl/sdram_memtest_master.sv
// Avalon-MM memory-test initiator: on start, writes NWORDS pattern words from
// BASE, reads them back with up to MAX_PEND pipelined reads and compares.
//   clk_clk, reset_reset_n : clock, async active-low reset
//   start                  : 1-cycle pulse, honoured in IDLE/DONE only
//   busy, done, pass       : test status (pass valid while done)
//   err_count              : saturating mismatch count
//   first_err_addr         : byte address of first mismatch (0 if none)
//   avm_*                  : Avalon-MM master port
// Option macro: MEMTEST_LFSR_EN (LFSR pattern instead of index^SEED).
module sdram_memtest_master
  import memtest_pkg::*;
#(
  parameter int          ADDR_W   = 25,
  parameter int          DATA_W   = 16,
  parameter int unsigned BASE     = 0,
  parameter int          NWORDS   = 1024,
  parameter int          MAX_PEND = 4,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid
);
  localparam int BE_W   = DATA_W / 8;
  localparam int CNT_W  = $clog2(NWORDS + 1);
  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d, issued_q, issued_d, received_q, received_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [15:0]         err_q, err_d;
  logic [ADDR_W-1:0]   ferr_q, ferr_d;
  logic [DATA_W-1:0]   wr_pat, chk_pat;
  logic                start_go, wr_acc, rd_acc, rdv_ok, mismatch;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [CNT_W-1:0] n);
    return ADDR_W'(BASE) + ADDR_W'(n) * ADDR_W'(BE_W);
  endfunction

  assign start_go = start && (state_q == IDLE || state_q == DONE);
  assign wr_acc   = avm_write && !avm_waitrequest;
  assign rd_acc   = avm_read && !avm_waitrequest;
  // Strobes with nothing outstanding (or outside READ) are stray and dropped.
  assign rdv_ok   = (state_q == READ) && avm_readdatavalid && (pend_q != '0);
  assign mismatch = rdv_ok && (avm_readdata != chk_pat);

  memtest_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_gen (
    .clk(clk_clk), .rst_n(reset_reset_n), .clear(start_go), .advance(wr_acc),
    .pattern(wr_pat));

  memtest_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_chk_gen (
    .clk(clk_clk), .rst_n(reset_reset_n), .clear(start_go), .advance(rdv_ok),
    .pattern(chk_pat));

  // State register
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start)                         state_d = WRITE;
      WRITE:      if (wr_acc && idx_q == LAST)       state_d = READ;
      READ:       if (rdv_ok && received_q == LAST)  state_d = DONE;
      default:                                       state_d = IDLE;
    endcase
  end

  // Outputs: all derived from registered state, so they hold during a stall.
  always_comb begin
    busy          = (state_q == WRITE) || (state_q == READ);
    done          = (state_q == DONE);
    pass          = (state_q == DONE) && (err_q == '0);
    avm_write     = (state_q == WRITE);
    avm_read      = (state_q == READ) && (issued_q < CNT_W'(NWORDS)) &&
                    (pend_q < PEND_W'(MAX_PEND));
    avm_address   = '0;
    avm_writedata = '0;
    if (avm_write) begin
      avm_address   = word_addr(idx_q);
      avm_writedata = wr_pat;
    end else if (avm_read) begin
      avm_address   = word_addr(issued_q);
    end
  end

  assign avm_byteenable = '1;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

  // Counters and result registers
  always_comb begin
    idx_d      = idx_q;
    issued_d   = issued_q;
    received_d = received_q;
    pend_d     = pend_q;
    err_d      = err_q;
    ferr_d     = ferr_q;
    if (start_go) begin
      idx_d      = '0;
      issued_d   = '0;
      received_d = '0;
      pend_d     = '0;
      err_d      = '0;
      ferr_d     = '0;
    end else begin
      if (wr_acc) idx_d    = idx_q + 1'b1;
      if (rd_acc) issued_d = issued_q + 1'b1;
      case ({rd_acc, rdv_ok})
        2'b10:   pend_d = pend_q + 1'b1;
        2'b01:   pend_d = pend_q - 1'b1;
        default: pend_d = pend_q;
      endcase
      if (rdv_ok) received_d = received_q + 1'b1;
      if (mismatch) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        // err_q never returns to zero once set, so it marks "first".
        if (err_q == '0) ferr_d = word_addr(received_q);
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      idx_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      pend_q     <= '0;
      err_q      <= '0;
      ferr_q     <= '0;
    end else begin
      idx_q      <= idx_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      ferr_q     <= ferr_d;
    end
endmodule
